apb2axi_32_64: RTL and testbench
================================

# apb2axi_32_64

APB-to-AXI4 bridge: a 32-bit APB completer that turns each APB transfer into one single-beat AXI4 transaction on a 64-bit AXI_BUS master port. It lets an APB-only initiator, such as a debug or boot sequencer on the peripheral bus, reach AXI memory and peripherals through the crossbar. It is the initiator-side counterpart of the existing AXI-to-APB peripheral path. It also adds a bounded-latency timeout, so a hung AXI target cannot stall the APB bus indefinitely.

## Interface
- AxiAddrWidth, 64: AXI address width; must be ≥ ApbAddrWidth.
- AxiDataWidth, 64: AXI data width. Only 64 is supported; elaboration fails otherwise.
- AxiIdWidth, 4: AXI ID width.
- AxiUserWidth, 1: AXI user width.
- ApbAddrWidth, 32: PADDR width.
- AxiId, 0: constant ID driven on aw_id and ar_id.
- AddrOffset, 0: AxiAddrWidth-bit value added to the zero-extended PADDR to form the AXI address.
- TimeoutCycles, 256: timeout length in cycles; 0 disables the timeout. Counter is 16 bits.
- clk_i  in  1  clock. All logic is in this single clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB direction (1 = write).
- PADDR  in  ApbAddrWidth  APB byte address.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready.
- PSLVERR  out  1  APB error.
- axi  AXI_BUS.Master  all AXI channels.

## Operation
- Constant AXI fields on every request:
  - len = 0, size = 3'b010 (4 bytes), burst = INCR.
  - lock, cache, prot, qos, region, user = 0.
  - w_last = 1.
  - b_ready = 1 only in WR_RESP and DRAIN; r_ready = 1 only in RD_RESP and DRAIN.
- Address: ax_addr = zero-extended PADDR + AddrOffset. PADDR[1:0] are forwarded unchanged; the bridge does no alignment check.
- Write data lane selection:
  - PADDR[2] = 0: w_data = {32'h0, PWDATA}, w_strb = 8'h0F.
  - PADDR[2] = 1: w_data = {PWDATA, 32'h0}, w_strb = 8'hF0.
- Read data: PRDATA takes r_data[31:0] or r_data[63:32], chosen by the PADDR[2] value captured at launch.
- Error: PSLVERR = resp[1], i.e. SLVERR and DECERR both map to error. Timeout also sets PSLVERR.
- Launch capture: address, data, direction and lane are registered at launch and held for the whole transaction.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, DRAIN.
- IDLE:
  - PSEL & PENABLE with PWRITE = 1 → WR_REQ; with PWRITE = 0 → RD_REQ.
  - PSEL without PENABLE (setup phase) does nothing.
- WR_REQ:
  - aw_valid and w_valid are asserted together.
  - Each is dropped individually after its own handshake; aw_done and w_done flags track this.
  - When both flags are set → WR_RESP.
- WR_RESP: on b_valid, capture resp → DONE.
- RD_REQ: ar_valid is held until ar_ready → RD_RESP.
- RD_RESP: on r_valid, capture r_data lane and resp → DONE.
- DONE:
  - PREADY = 1 for exactly one cycle, with PRDATA and PSLVERR valid → IDLE.
  - PRDATA is updated only by reads and holds its value otherwise.
- Timeout:
  - The counter clears on leaving IDLE and increments every cycle in the REQ and RESP states.
  - When it reaches TimeoutCycles → DONE with PSLVERR = 1 and PRDATA = 0.
  - The same transition also records which AXI handshakes are still outstanding.
- DRAIN (entered from DONE whenever a timeout occurred):
  - Any pending valids stay asserted until their handshake; AXI rules forbid retracting them.
  - The late b or r response is then accepted and discarded → IDLE.
  - PREADY stays 0 in DRAIN, so a new APB access waits in its access phase until the bridge returns to IDLE.
- A b or r beat arriving in any state other than RESP or DRAIN is a protocol violation. The bridge does not accept it (ready = 0).
- Reset, at any point including mid-transaction:
  - The FSM returns to IDLE.
  - All valid signals, PREADY, PSLVERR and PRDATA go to 0, and the counter clears.
  - The system resets the AXI target alongside the bridge.

## Timing
- PREADY is registered: it is never asserted in the same cycle that PSEL & PENABLE is first seen.
- Minimum write, with aw_ready, w_ready and b_valid all ready immediately:
  - Access cycle A0 is seen in IDLE; aw_valid and w_valid are high in A1 and handshake in A1.
  - b_valid is accepted in A2; PREADY = 1 in A3.
  - The APB access phase therefore lasts 4 cycles.
- Minimum read: ar handshake in A1, r accepted in A2, PREADY in A3.
- aw and w may handshake in different cycles. The FSM leaves WR_REQ in the cycle after the later of the two handshakes.
- Timeout boundary: a response beat in the same cycle the counter reaches TimeoutCycles wins. The transaction completes normally with no error and no DRAIN.
- Back-to-back: the next transfer's setup phase may coincide with DONE. Its access phase is then sampled in IDLE one cycle later.

## Test plan
- Write, aligned lane 0:
  - Stimulus: PADDR = 0x1000_0000, PWDATA = 0xCAFE_F00D, AddrOffset = 0, AXI always ready with OKAY response.
  - Required: aw_addr = 0x1000_0000, w_data = 0x0000_0000_CAFE_F00D, w_strb = 0x0F, PREADY in A3, PSLVERR = 0.
- Read, upper lane:
  - Stimulus: PADDR = 0x0000_0104, r_data = 0x1122_3344_5566_7788.
  - Required: PRDATA = 0x1122_3344, ar_size = 2.
- Skewed write:
  - Stimulus: aw_ready delayed 5 cycles, w_ready immediate.
  - Required: w_valid drops after its handshake while aw_valid stays high; exactly one b accepted; PREADY exactly once.
- Error mapping:
  - Stimulus: b_resp = 2'b11 (DECERR) on a write, r_resp = 2'b10 (SLVERR) on a read.
  - Required: PSLVERR = 1 on both; PRDATA still takes the r_data lane.
- Timeout and drain:
  - Stimulus: TimeoutCycles = 8; the target withholds b_valid for 20 cycles.
  - Required: PREADY with PSLVERR = 1 at about 8 cycles; late b is absorbed in DRAIN; the next read completes normally with the correct data.
- Reset mid-read:
  - Stimulus: rst_ni asserted during RD_RESP.
  - Required: all valid signals, PREADY and PRDATA are 0 immediately; after release, the next transfer is normal.

Source files
------------

// File: rtl/apb2axi_32_64_if.sv
// AXI4 bus bundle: one instance per master/slave link, with Master and Slave views.
interface AXI_BUS #(
   parameter int unsigned AXI_ADDR_WIDTH = 64,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 4,
   parameter int unsigned AXI_USER_WIDTH = 1
);
   localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

   logic [AXI_ID_WIDTH-1:0]   aw_id;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr;
   logic [7:0]                aw_len;
   logic [2:0]                aw_size;
   logic [1:0]                aw_burst;
   logic                      aw_lock;
   logic [3:0]                aw_cache;
   logic [2:0]                aw_prot;
   logic [3:0]                aw_qos;
   logic [3:0]                aw_region;
   logic [AXI_USER_WIDTH-1:0] aw_user;
   logic                      aw_valid;
   logic                      aw_ready;

   logic [AXI_DATA_WIDTH-1:0] w_data;
   logic [AXI_STRB_WIDTH-1:0] w_strb;
   logic                      w_last;
   logic [AXI_USER_WIDTH-1:0] w_user;
   logic                      w_valid;
   logic                      w_ready;

   logic [AXI_ID_WIDTH-1:0]   b_id;
   logic [1:0]                b_resp;
   logic [AXI_USER_WIDTH-1:0] b_user;
   logic                      b_valid;
   logic                      b_ready;

   logic [AXI_ID_WIDTH-1:0]   ar_id;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr;
   logic [7:0]                ar_len;
   logic [2:0]                ar_size;
   logic [1:0]                ar_burst;
   logic                      ar_lock;
   logic [3:0]                ar_cache;
   logic [2:0]                ar_prot;
   logic [3:0]                ar_qos;
   logic [3:0]                ar_region;
   logic [AXI_USER_WIDTH-1:0] ar_user;
   logic                      ar_valid;
   logic                      ar_ready;

   logic [AXI_ID_WIDTH-1:0]   r_id;
   logic [AXI_DATA_WIDTH-1:0] r_data;
   logic [1:0]                r_resp;
   logic                      r_last;
   logic [AXI_USER_WIDTH-1:0] r_user;
   logic                      r_valid;
   logic                      r_ready;

   modport Master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );

   modport Slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );
endinterface

// File: rtl/apb2axi_32_64.sv
// APB completer that issues one single-beat AXI4 transaction per APB transfer,
// with a bounded-latency timeout and a drain phase for late responses.
module apb2axi_32_64 #(
   parameter int unsigned                AxiAddrWidth  = 64,
   parameter int unsigned                AxiDataWidth  = 64,
   parameter int unsigned                AxiIdWidth    = 4,
   parameter int unsigned                AxiUserWidth  = 1,
   parameter int unsigned                ApbAddrWidth  = 32,
   parameter logic [AxiIdWidth-1:0]      AxiId         = '0,
   parameter logic [AxiAddrWidth-1:0]    AddrOffset    = '0,
   parameter int unsigned                TimeoutCycles = 256
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ApbAddrWidth-1:0] PADDR,
   input  logic [31:0]             PWDATA,
   output logic [31:0]             PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR,
   AXI_BUS.Master                  axi
);

   if (AxiDataWidth != 64) begin : g_bad_data_width
      $error("apb2axi_32_64: only AxiDataWidth = 64 is supported");
   end
   if (AxiAddrWidth < ApbAddrWidth) begin : g_bad_addr_width
      $error("apb2axi_32_64: AxiAddrWidth must be >= ApbAddrWidth");
   end

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, DRAIN} state_t;

   state_t                  state;
   logic [15:0]             cnt;
   logic                    write_q;
   logic                    lane_q;
   logic                    timed_out;
   logic                    aw_done;
   logic                    w_done;
   logic [AxiAddrWidth-1:0] ax_addr_q;
   logic [63:0]             w_data_q;
   logic [7:0]              w_strb_q;
   logic                    aw_valid_q;
   logic                    w_valid_q;
   logic                    ar_valid_q;
   logic                    b_ready_q;
   logic                    r_ready_q;
   logic                    pready_q;
   logic                    pslverr_q;
   logic [31:0]             prdata_q;

   logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic waiting, progress, expired;

   assign aw_hs = aw_valid_q & axi.aw_ready;
   assign w_hs  = w_valid_q  & axi.w_ready;
   assign ar_hs = ar_valid_q & axi.ar_ready;
   assign b_hs  = b_ready_q  & axi.b_valid;
   assign r_hs  = r_ready_q  & axi.r_valid;

   assign waiting = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_RESP);
   assign expired = (TimeoutCycles != 0) && (cnt == 16'(TimeoutCycles));

   always_comb begin
      progress = 1'b0;
      case (state)
         WR_REQ:  progress = (aw_done | aw_hs) & (w_done | w_hs);
         WR_RESP: progress = b_hs;
         RD_REQ:  progress = ar_hs;
         RD_RESP: progress = r_hs;
         default: progress = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         cnt        <= '0;
         write_q    <= 1'b0;
         lane_q     <= 1'b0;
         timed_out  <= 1'b0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         ax_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         b_ready_q  <= 1'b0;
         r_ready_q  <= 1'b0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
         prdata_q   <= '0;
      end else begin
         // Request valids retire on their own handshake in every state, so a
         // request still pending at timeout completes during DONE/DRAIN.
         if (aw_hs) aw_valid_q <= 1'b0;
         if (w_hs)  w_valid_q  <= 1'b0;
         if (ar_hs) ar_valid_q <= 1'b0;
         if (aw_hs) aw_done    <= 1'b1;
         if (w_hs)  w_done     <= 1'b1;
         if (waiting) cnt <= cnt + 16'd1;

         case (state)
            IDLE: begin
               if (PSEL && PENABLE) begin
                  cnt       <= '0;
                  timed_out <= 1'b0;
                  aw_done   <= 1'b0;
                  w_done    <= 1'b0;
                  ax_addr_q <= AxiAddrWidth'(PADDR) + AddrOffset;
                  lane_q    <= PADDR[2];
                  write_q   <= PWRITE;
                  if (PWRITE) begin
                     w_data_q   <= PADDR[2] ? {PWDATA, 32'h0} : {32'h0, PWDATA};
                     w_strb_q   <= PADDR[2] ? 8'hF0 : 8'h0F;
                     aw_valid_q <= 1'b1;
                     w_valid_q  <= 1'b1;
                     state      <= WR_REQ;
                  end else begin
                     ar_valid_q <= 1'b1;
                     state      <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (progress) begin
                  b_ready_q <= 1'b1;
                  state     <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (b_hs) begin
                  b_ready_q <= 1'b0;
                  pslverr_q <= axi.b_resp[1];
                  pready_q  <= 1'b1;
                  state     <= DONE;
               end
            end
            RD_REQ: begin
               if (progress) begin
                  r_ready_q <= 1'b1;
                  state     <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (r_hs) begin
                  r_ready_q <= 1'b0;
                  prdata_q  <= lane_q ? axi.r_data[63:32] : axi.r_data[31:0];
                  pslverr_q <= axi.r_resp[1];
                  pready_q  <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               pready_q <= 1'b0;
               if (timed_out) begin
                  b_ready_q <= write_q;
                  r_ready_q <= ~write_q;
                  state     <= DRAIN;
               end else begin
                  state <= IDLE;
               end
            end
            DRAIN: begin
               if (b_hs || r_hs) begin
                  b_ready_q <= 1'b0;
                  r_ready_q <= 1'b0;
                  timed_out <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Overrides the per-state updates; a response arriving on the expiry
         // cycle counts as progress and completes normally.
         if (waiting && !progress && expired) begin
            b_ready_q <= 1'b0;
            r_ready_q <= 1'b0;
            pslverr_q <= 1'b1;
            prdata_q  <= '0;
            pready_q  <= 1'b1;
            timed_out <= 1'b1;
            state     <= DONE;
         end
      end
   end

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

   assign axi.aw_id     = AxiId;
   assign axi.aw_addr   = ax_addr_q;
   assign axi.aw_len    = '0;
   assign axi.aw_size   = 3'b010;
   assign axi.aw_burst  = 2'b01;
   assign axi.aw_lock   = 1'b0;
   assign axi.aw_cache  = '0;
   assign axi.aw_prot   = '0;
   assign axi.aw_qos    = '0;
   assign axi.aw_region = '0;
   assign axi.aw_user   = {AxiUserWidth{1'b0}};
   assign axi.aw_valid  = aw_valid_q;

   assign axi.w_data  = w_data_q;
   assign axi.w_strb  = w_strb_q;
   assign axi.w_last  = 1'b1;
   assign axi.w_user  = {AxiUserWidth{1'b0}};
   assign axi.w_valid = w_valid_q;

   assign axi.b_ready = b_ready_q;

   assign axi.ar_id     = AxiId;
   assign axi.ar_addr   = ax_addr_q;
   assign axi.ar_len    = '0;
   assign axi.ar_size   = 3'b010;
   assign axi.ar_burst  = 2'b01;
   assign axi.ar_lock   = 1'b0;
   assign axi.ar_cache  = '0;
   assign axi.ar_prot   = '0;
   assign axi.ar_qos    = '0;
   assign axi.ar_region = '0;
   assign axi.ar_user   = {AxiUserWidth{1'b0}};
   assign axi.ar_valid  = ar_valid_q;

   assign axi.r_ready = r_ready_q;

   logic unused_axi;
   assign unused_axi = ^{axi.b_id, axi.b_resp[0], axi.b_user,
                         axi.r_id, axi.r_resp[0], axi.r_last, axi.r_user};

endmodule

// File: tb/tb_apb2axi_32_64.sv
// Directed bench for apb2axi_32_64: APB transfers against a configurable AXI target.
module tb_apb2axi_32_64;

   logic        clk;
   logic        rst_n;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] prdata;
   logic        pready, pslverr;

   AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) axi ();

   apb2axi_32_64 #(
      .AxiAddrWidth(64), .AxiDataWidth(64), .AxiIdWidth(4), .AxiUserWidth(1),
      .ApbAddrWidth(32), .AxiId(4'h0), .AddrOffset(64'h0), .TimeoutCycles(8)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
      .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
      .axi(axi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // target knobs and observations
   int          aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
   logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
   logic [63:0] r_data_cfg = '0;
   int          aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0, pready_n = 0, skew_n = 0, wrep_n = 0;
   logic [63:0] aw_addr_seen = '0, ar_addr_seen = '0, w_data_seen = '0;
   logic [7:0]  w_strb_seen = '0, aw_len_seen = '0, ar_len_seen = '0;
   logic [2:0]  aw_size_seen = '0, ar_size_seen = '0;
   logic        w_last_seen = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
      @(posedge clk); #1;
      penable = 1'b1;
      lat = 0;
      forever begin
         @(negedge clk);
         if (pready || lat > 200) break;
         lat++;
      end
      check("apb_wait_bound", 64'(lat > 200), 64'(0));
      rdata = prdata;
      err   = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   // AXI target: handshakes sampled at negedge, drives updated 1 after posedge
   initial begin : axi_target
      bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
      bit aw_got, w_got, ar_got;
      int aw_wait, w_wait, b_wait, r_wait;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; r_wait = 0;
      axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
      axi.b_valid = 1'b0; axi.b_resp = 2'b00; axi.b_id = '0; axi.b_user = '0;
      axi.r_valid = 1'b0; axi.r_resp = 2'b00; axi.r_id = '0; axi.r_user = '0;
      axi.r_data = '0; axi.r_last = 1'b0;
      forever begin
         @(negedge clk);
         aw_hs = axi.aw_valid && axi.aw_ready;
         w_hs  = axi.w_valid && axi.w_ready;
         ar_hs = axi.ar_valid && axi.ar_ready;
         b_hs  = axi.b_valid && axi.b_ready;
         r_hs  = axi.r_valid && axi.r_ready;
         if (pready) pready_n++;
         if (axi.aw_valid && !axi.w_valid && w_got) skew_n++;
         if (axi.w_valid && w_got) wrep_n++;
         if (aw_hs) begin
            aw_n++; aw_addr_seen = axi.aw_addr; aw_size_seen = axi.aw_size; aw_len_seen = axi.aw_len;
         end
         if (w_hs) begin
            w_n++; w_data_seen = axi.w_data; w_strb_seen = axi.w_strb; w_last_seen = axi.w_last;
         end
         if (ar_hs) begin
            ar_n++; ar_addr_seen = axi.ar_addr; ar_size_seen = axi.ar_size; ar_len_seen = axi.ar_len;
         end
         if (b_hs) b_n++;
         if (r_hs) r_n++;
         @(posedge clk); #1;
         if (!rst_n) begin
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; r_wait = 0;
            axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
            axi.b_valid = 1'b0; axi.r_valid = 1'b0;
            continue;
         end
         if (aw_hs) begin aw_got = 1; aw_wait = 0; end
         if (w_hs)  begin w_got = 1; w_wait = 0; end
         if (ar_hs) ar_got = 1;
         if (b_hs)  begin axi.b_valid = 1'b0; aw_got = 0; w_got = 0; b_wait = 0; end
         if (r_hs)  begin axi.r_valid = 1'b0; ar_got = 0; r_wait = 0; end
         axi.aw_ready = 1'b0;
         if (axi.aw_valid) begin
            if (aw_wait >= aw_delay) axi.aw_ready = 1'b1;
            else aw_wait++;
         end
         axi.w_ready = 1'b0;
         if (axi.w_valid) begin
            if (w_wait >= w_delay) axi.w_ready = 1'b1;
            else w_wait++;
         end
         axi.ar_ready = axi.ar_valid;
         if (aw_got && w_got && !axi.b_valid) begin
            if (b_wait >= b_delay) begin axi.b_valid = 1'b1; axi.b_resp = b_resp_cfg; end
            else b_wait++;
         end
         if (ar_got && !axi.r_valid) begin
            if (r_wait >= r_delay) begin
               axi.r_valid = 1'b1; axi.r_resp = r_resp_cfg; axi.r_data = r_data_cfg; axi.r_last = 1'b1;
            end else r_wait++;
         end
      end
   end

   initial begin : stimulus
      logic [31:0] rd;
      logic        er;
      int          lat, b0, p0, w0;
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pready",   64'(pready), 64'(0));
      check("rst_pslverr",  64'(pslverr), 64'(0));
      check("rst_prdata",   64'(prdata), 64'(0));
      check("rst_aw_valid", 64'(axi.aw_valid), 64'(0));
      check("rst_w_valid",  64'(axi.w_valid), 64'(0));
      check("rst_ar_valid", 64'(axi.ar_valid), 64'(0));
      check("rst_b_ready",  64'(axi.b_ready), 64'(0));
      check("rst_r_ready",  64'(axi.r_ready), 64'(0));
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // write, lane 0
      p0 = pready_n;
      apb(1'b1, 32'h1000_0000, 32'hCAFE_F00D, rd, er, lat);
      check("wr0_latency", 64'(lat), 64'd3);
      check("wr0_pslverr", 64'(er), 64'(0));
      check("wr0_aw_addr", aw_addr_seen, 64'h0000_0000_1000_0000);
      check("wr0_w_data",  w_data_seen, 64'h0000_0000_CAFE_F00D);
      check("wr0_w_strb",  64'(w_strb_seen), 64'h0F);
      check("wr0_w_last",  64'(w_last_seen), 64'(1));
      check("wr0_aw_size", 64'(aw_size_seen), 64'd2);
      check("wr0_aw_len",  64'(aw_len_seen), 64'd0);
      check("wr0_pready_pulses", 64'(pready_n - p0), 64'd1);

      // read, upper lane
      r_data_cfg = 64'h1122_3344_5566_7788; r_resp_cfg = 2'b00;
      apb(1'b0, 32'h0000_0104, 32'h0, rd, er, lat);
      check("rd1_prdata",  64'(rd), 64'h1122_3344);
      check("rd1_pslverr", 64'(er), 64'(0));
      check("rd1_latency", 64'(lat), 64'd3);
      check("rd1_ar_size", 64'(ar_size_seen), 64'd2);
      check("rd1_ar_addr", ar_addr_seen, 64'h104);
      check("rd1_ar_len",  64'(ar_len_seen), 64'd0);

      // write upper lane with DECERR; PRDATA must keep the last read value
      b_resp_cfg = 2'b11;
      apb(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, rd, er, lat);
      check("wr2_pslverr", 64'(er), 64'(1));
      check("wr2_w_data",  w_data_seen, 64'hDEAD_BEEF_0000_0000);
      check("wr2_w_strb",  64'(w_strb_seen), 64'hF0);
      check("wr2_prdata_hold", 64'(rd), 64'h1122_3344);
      b_resp_cfg = 2'b00;

      // read lane 0 with SLVERR; data lane still taken
      r_data_cfg = 64'hAAAA_BBBB_CCCC_DDDD; r_resp_cfg = 2'b10;
      apb(1'b0, 32'h0000_3000, 32'h0, rd, er, lat);
      check("rd3_pslverr", 64'(er), 64'(1));
      check("rd3_prdata",  64'(rd), 64'hCCCC_DDDD);
      r_resp_cfg = 2'b00;

      // skewed write: aw_ready 5 cycles late
      aw_delay = 5; b0 = b_n; p0 = pready_n; w0 = w_n; skew_n = 0; wrep_n = 0;
      apb(1'b1, 32'h0000_4000, 32'h1234_5678, rd, er, lat);
      aw_delay = 0;
      check("skew_latency", 64'(lat), 64'd8);
      check("skew_pslverr", 64'(er), 64'(0));
      check("skew_w_dropped_cycles", 64'(skew_n), 64'd5);
      check("skew_w_reasserted", 64'(wrep_n), 64'd0);
      check("skew_w_beats", 64'(w_n - w0), 64'd1);
      check("skew_b_beats", 64'(b_n - b0), 64'd1);
      check("skew_pready_pulses", 64'(pready_n - p0), 64'd1);

      // response on the expiry cycle wins
      b_delay = 7;
      apb(1'b1, 32'h0000_5000, 32'h0000_0001, rd, er, lat);
      b_delay = 0;
      check("edge_latency", 64'(lat), 64'd10);
      check("edge_pslverr", 64'(er), 64'(0));
      r_data_cfg = 64'h0BAD_0BAD_600D_600D;
      apb(1'b0, 32'h0000_5008, 32'h0, rd, er, lat);
      check("edge_next_latency", 64'(lat), 64'd3);
      check("edge_next_prdata", 64'(rd), 64'h600D_600D);

      // timeout and drain
      b_delay = 20; b0 = b_n; p0 = pready_n;
      apb(1'b1, 32'h0000_6000, 32'h5555_AAAA, rd, er, lat);
      check("to_latency", 64'(lat), 64'd10);
      check("to_pslverr", 64'(er), 64'(1));
      check("to_prdata",  64'(rd), 64'h0);
      r_data_cfg = 64'h0123_4567_89AB_CDEF;
      apb(1'b0, 32'h0000_0010, 32'h0, rd, er, lat);
      b_delay = 0;
      check("drain_read_prdata",  64'(rd), 64'h89AB_CDEF);
      check("drain_read_pslverr", 64'(er), 64'(0));
      check("drain_read_waited",  64'(lat > 3), 64'(1));
      check("drain_b_beats", 64'(b_n - b0), 64'd1);
      check("drain_pready_pulses", 64'(pready_n - p0), 64'd2);

      // reset in RD_RESP
      r_delay = 10;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_0008;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk);
      @(posedge clk); #2;
      check("rstmid_in_rd_resp", 64'(axi.r_ready), 64'(1));
      #1 rst_n = 1'b0;
      #1;
      check("rstmid_ar_valid", 64'(axi.ar_valid), 64'(0));
      check("rstmid_aw_valid", 64'(axi.aw_valid), 64'(0));
      check("rstmid_w_valid",  64'(axi.w_valid), 64'(0));
      check("rstmid_r_ready",  64'(axi.r_ready), 64'(0));
      check("rstmid_pready",   64'(pready), 64'(0));
      check("rstmid_prdata",   64'(prdata), 64'(0));
      psel = 1'b0; penable = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      r_delay = 0;
      @(posedge clk); #1;
      r_data_cfg = 64'hFEDC_BA98_7654_3210;
      apb(1'b0, 32'h0000_000C, 32'h0, rd, er, lat);
      check("post_rst_prdata",  64'(rd), 64'hFEDC_BA98);
      check("post_rst_pslverr", 64'(er), 64'(0));
      check("post_rst_latency", 64'(lat), 64'd3);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
